// File: rtl/led_pkg.sv
// Purpose: shared mode encoding, switch match values and decode helper for the LED pattern generator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package led_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'd0,
        MODE_SHL    = 3'd1,
        MODE_SHR    = 3'd2,
        MODE_INV    = 3'd3,
        MODE_COUNT  = 3'd4,
        MODE_ROTL   = 3'd5,
        MODE_BOUNCE = 3'd6
    } mode_e;

    // Debounced switch values that select each mode. The whole word is
    // compared, so stray upper bits fall through to COUNT.
    localparam logic [31:0] MATCH_HOLD   = 32'h0000_0001;
    localparam logic [31:0] MATCH_SHL    = 32'h0000_0002;
    localparam logic [31:0] MATCH_SHR    = 32'h0000_0004;
    localparam logic [31:0] MATCH_INV    = 32'h0000_0008;
    localparam logic [31:0] MATCH_ROTL   = 32'h0000_0010;
    localparam logic [31:0] MATCH_BOUNCE = 32'h0000_0020;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic mode_e decode_mode(input logic [31:0] sw_val);
        mode_e m;
        case (sw_val)
            MATCH_HOLD:   m = MODE_HOLD;
            MATCH_SHL:    m = MODE_SHL;
            MATCH_SHR:    m = MODE_SHR;
            MATCH_INV:    m = MODE_INV;
            MATCH_ROTL:   m = MODE_ROTL;
            MATCH_BOUNCE: m = MODE_BOUNCE;
            default:      m = MODE_COUNT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Purpose: 2-flop synchronizer plus stability debouncer for a bank of raw switches.
// Latency: 2 sync cycles + DEB_CYCLES stable cycles before sw_db_o follows a new value.
// Backpressure: none; free-running sampler.
// Ports: clk, rst_n (async active-low), sw_i [W] raw switches, sw_db_o [W] debounced value.
module sw_debounce #(
    parameter int W          = 8,
    parameter int DEB_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw_i,
    output logic [W-1:0] sw_db_o
);

    localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [W-1:0]  sync1_q, sync2_q, db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts cycles that sync2_q has held one value different from db_q.
    // sync1_q is one cycle ahead of sync2_q, so a mismatch there means sync2_q
    // is about to change and the window must restart. The commit test comes
    // first so a value that has already served its full window is taken even
    // if the input moves on in the same cycle.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else if (sync1_q != sync2_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sw_db_o = db_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Purpose: switch-selected LED pattern engine stepping on a speed-scaled tick.
// Latency: led_out/tick_o change together at the tick edge; mode_o is decode of debounced switches + 1 cycle.
// Backpressure: none; free-running.
// Ports: clk, rst_n (async active-low), sw [SW_W] raw switches, speed [2] rate select,
//        led_out [LED_W] pattern register, tick_o step strobe, mode_o [3] current mode.
module led_pattern_gen #(
    parameter int LED_W      = 8,
    parameter int SW_W       = 8,
    parameter int TICK_DIV   = 100000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SW_W-1:0]  sw,
    input  logic [1:0]       speed,
    output logic [LED_W-1:0] led_out,
    output logic             tick_o,
    output logic [2:0]       mode_o
);
    import led_pkg::*;

    localparam int               DIV_W = $clog2(TICK_DIV);
    localparam logic [LED_W-1:0] ONE   = LED_W'(1);

    logic [SW_W-1:0]  sw_db;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W:0]   period, period_m1;
    logic             tick_hit, tick_q;
    mode_e            mode_q, mode_d;
    logic [LED_W-1:0] pat_q, pat_d, bnc;
    logic             dir_q, dir_d;

    sw_debounce #(
        .W          (SW_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sw_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_i    (sw),
        .sw_db_o (sw_db)
    );

    // ">=" rather than "==" so a speed-up that lands below the current count
    // ticks on the next cycle instead of running on to wrap.
    always_comb begin
        period    = (DIV_W + 1)'(TICK_DIV) >> speed;
        period_m1 = period - (DIV_W + 1)'(1);
        tick_hit  = ({1'b0, div_q} >= period_m1);
        div_d     = tick_hit ? '0 : div_q + DIV_W'(1);
    end

    always_comb begin
        mode_d = decode_mode(32'(sw_db));
    end

    // Pattern step; uses the registered mode so a new mode applies from the
    // first tick after mode_o shows it. Shift-type modes seed an empty word.
    always_comb begin
        pat_d = pat_q;
        dir_d = dir_q;
        bnc   = '0;
        if (tick_hit) begin
            case (mode_q)
                MODE_HOLD: pat_d = pat_q;
                MODE_SHL:  pat_d = (pat_q == '0) ? ONE : (pat_q << 1);
                MODE_SHR:  pat_d = (pat_q == '0) ? ONE : (pat_q >> 1);
                MODE_INV:  pat_d = ~pat_q;
                MODE_ROTL: pat_d = (pat_q == '0) ? ONE : {pat_q[LED_W-2:0], pat_q[LED_W-1]};
                MODE_BOUNCE: begin
                    if (pat_q == '0) begin
                        bnc = ONE;
                    end else if (dir_q == DIR_LEFT) begin
                        bnc = pat_q << 1;
                    end else begin
                        bnc = pat_q >> 1;
                    end
                    pat_d = bnc;
                    // MSB wins when both ends are lit.
                    if (bnc[LED_W-1]) begin
                        dir_d = DIR_RIGHT;
                    end else if (bnc[0]) begin
                        dir_d = DIR_LEFT;
                    end
                end
                default:   pat_d = pat_q + ONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            mode_q <= MODE_COUNT;
            pat_q  <= '0;
            dir_q  <= DIR_LEFT;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_hit;
            mode_q <= mode_d;
            pat_q  <= pat_d;
            dir_q  <= dir_d;
        end
    end

    assign led_out = pat_q;
    assign tick_o  = tick_q;
    assign mode_o  = mode_q;

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter LED_W, default 8: number of LED outputs; legal range 2..32.
REQ-002 Parameter SW_W, default 8: switch input width; legal range 6..32.
REQ-003 Parameter TICK_DIV, default 100000000: base step period in clk cycles; legal range 8..2^28.
REQ-004 Parameter DEB_CYCLES, default 1000000: debounce stability window in clk cycles; minimum 1.
REQ-005 clk, input, 1: system clock; all state is on its rising edge.
REQ-006 rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 sw, input, SW_W: raw asynchronous mode switches.
REQ-008 speed, input, 2: step rate select; synchronous to clk.
REQ-009 led_out, output, LED_W: registered LED pattern.
REQ-010 tick_o, output, 1: one-cycle strobe, high in the cycle the pattern updates.
REQ-011 mode_o, output, 3: registered current decoded mode, for status and debug.

Function
REQ-012 sw SHALL pass through a 2-flop synchronizer and then a debouncer; sw_db SHALL take the synchronized value only after that value has been stable for DEB_CYCLES consecutive cycles.
REQ-013 The tick period SHALL be P = TICK_DIV >> speed; the divider SHALL count 0..P-1, pulse tick for one cycle at P-1, and return to 0.
REQ-014 If speed changes so that the count is already >= P-1, the next cycle SHALL tick and clear the divider; no wrap through 2^28.
REQ-015 Mode decode from sw_db by exact match: 0x01 HOLD, 0x02 SHL, 0x04 SHR, 0x08 INV, 0x10 ROTL, 0x20 BOUNCE; any other value is COUNT. Upper bits of sw_db above bit 5 are part of the compare.
REQ-016 mode_o SHALL be the registered decode, updated every cycle, independent of tick.
REQ-017 The pattern SHALL change only in a tick cycle; between ticks led_out SHALL hold.
REQ-018 HOLD: pattern unchanged.
REQ-019 SHL: logical shift left by 1, zero fill. SHR: logical shift right by 1, zero fill.
REQ-020 INV: bitwise invert.
REQ-021 COUNT: increment modulo 2^LED_W; all-ones wraps to 0.
REQ-022 ROTL: rotate left by 1; the MSB moves to the LSB.
REQ-023 Seed rule: in SHL, SHR, ROTL or BOUNCE, a tick on an all-zero pattern SHALL load 1 instead of applying the operation.
REQ-024 BOUNCE: a direction flag (reset = left) selects shift left or right by 1.
REQ-025 BOUNCE at the ends: if the result reaches bit LED_W-1 the flag flips to right; if it reaches bit 0 the flag flips to left.
REQ-026 BOUNCE with more than one bit set SHALL shift the whole word per the flag, zero fill. Flip checks use the result's MSB and LSB, and MSB takes priority.
REQ-027 A mode change SHALL take effect at the first tick after mode_o updates; the pattern is not reset on a mode change.
REQ-028 Leaving BOUNCE SHALL preserve the direction flag.
REQ-029 led_out SHALL equal the pattern register directly, with no combinational path from sw or speed.

Reset
REQ-030 While rst_n is low: led_out = 0, tick_o = 0, mode_o = COUNT, divider = 0, direction = left, sync and debounce registers = 0, sw_db = 0, debounce counter = 0.
REQ-031 Reset assertion mid-period SHALL clear all state immediately; after release the first tick SHALL come exactly P cycles later.

Structure
REQ-032 Package led_pkg SHALL hold the mode enum (3-bit: HOLD, SHL, SHR, INV, COUNT, ROTL, BOUNCE) and the mode match constants.
REQ-033 The synchronizer and debouncer SHALL be one sub-module, sw_debounce, parametrised by width and DEB_CYCLES; everything else stays in led_pattern_gen.

Verification (TICK_DIV=16, DEB_CYCLES=4, LED_W=8, SW_W=8)
REQ-034 Default COUNT: sw=0, speed=0 -> tick every 16 cycles; led_out goes 0,1,2,...; after 255 it wraps to 0.
REQ-035 Debounce: sw toggles 0x02 for 3 cycles, then 0 -> mode_o stays COUNT. sw held at 0x02 -> mode_o = SHL 2+4+1 cycles after the change.
REQ-036 Seed and BOUNCE: sw=0x20 from pattern 0 -> 0x01, 0x02, ..., 0x80, 0x40, ..., 0x01, 0x02 with direction flips at both ends.
REQ-037 Speed: speed changes 0->3 with the divider at 10 -> tick next cycle, then every 2 cycles.
REQ-038 INV/ROTL: pattern 0x81 in ROTL -> 0x03. Then INV -> 0xFC, then 0x03. SHL from 0x80 -> 0x00, then seed 0x01.
REQ-039 Reset: rst_n pulsed low mid-period -> all outputs 0, mode_o = COUNT; first tick comes 16 cycles after release.
